// File: rtl/cpu_pkg.sv
// Shared encodings for the datapath: write-back select, shifter ops, ALU ops
// and status-bit positions. The ALU op values match the controller's op field.
package cpu_pkg;

   localparam int CPU_DATA_W = 16;
   localparam int CPU_NREG   = 8;
   localparam int REG_W      = 3;

   typedef enum logic [1:0] {
      VSEL_MDATA  = 2'b00,
      VSEL_SXIMM8 = 2'b01,
      VSEL_PC     = 2'b10,
      VSEL_C      = 2'b11
   } vsel_e;

   typedef enum logic [1:0] {
      SH_PASS = 2'b00,
      SH_LSL1 = 2'b01,
      SH_LSR1 = 2'b10,
      SH_ASR1 = 2'b11
   } shift_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_CMP = 2'b01,
      ALU_AND = 2'b10,
      ALU_MVN = 2'b11
   } aluop_e;

   localparam int STAT_Z = 0;
   localparam int STAT_N = 1;
   localparam int STAT_V = 2;

endpackage

// File: rtl/cpu_datapath_if.sv
// Control, decoder and result signals between the controller/decoder (master)
// and the datapath (slave).
interface cpu_datapath_if #(
   parameter int DATA_W = 16
);
   logic [2:0]        readnum;
   logic [2:0]        writenum;
   logic              write;
   logic [1:0]        vsel;
   logic              loada;
   logic              loadb;
   logic              loadc;
   logic              loads;
   logic              asel;
   logic              bsel;
   logic [1:0]        shift;
   logic [1:0]        ALUop;
   logic [DATA_W-1:0] sximm8;
   logic [DATA_W-1:0] sximm5;
   logic [DATA_W-1:0] mdata;
   logic [7:0]        PC;
   logic [DATA_W-1:0] datapath_out;
   logic [2:0]        status_out;

   modport master (
      output readnum, writenum, write, vsel, loada, loadb, loadc, loads,
             asel, bsel, shift, ALUop, sximm8, sximm5, mdata, PC,
      input  datapath_out, status_out
   );

   modport slave (
      input  readnum, writenum, write, vsel, loada, loadb, loadc, loads,
             asel, bsel, shift, ALUop, sximm8, sximm5, mdata, PC,
      output datapath_out, status_out
   );
endinterface

// File: rtl/cpu_regfile.sv
// General register file: combinational read port, synchronous write port.
// Every register clears on reset, so each entry is its own flop bank.
module cpu_regfile
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int NREG   = CPU_NREG
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              write,
   input  logic [REG_W-1:0]  writenum,
   input  logic [REG_W-1:0]  readnum,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
);

   logic [DATA_W-1:0] regs [NREG];

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
         logic [DATA_W-1:0] r_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               r_reg <= '0;
            end else if (write && (writenum == REG_W'(gi))) begin
               r_reg <= data_in;
            end
         end

         assign regs[gi] = r_reg;
      end
   endgenerate

   // Read returns the pre-write value when reading and writing the same index.
   assign data_out = regs[readnum];

endmodule

// File: rtl/cpu_datapath.sv
// Datapath: register file, A/B/C operand and result registers, shifter on B,
// ALU and {V,N,Z} status register, all steered by the controller's enables.
module cpu_datapath
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int NREG   = CPU_NREG
) (
   input  logic               clk,
   input  logic               reset,
   cpu_datapath_if.slave      bus
);

   localparam int MSB = DATA_W - 1;

   logic [DATA_W-1:0] read_data;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] a_reg, b_reg, c_reg;
   logic [2:0]        status_reg;
   logic [DATA_W-1:0] shift_out;
   logic [DATA_W-1:0] ain, bin;
   logic [DATA_W-1:0] alu_out;
   logic              ovf;
   logic [2:0]        flags;

   always_comb begin
      write_data = '0;
      case (bus.vsel)
         VSEL_MDATA:  write_data = bus.mdata;
         VSEL_SXIMM8: write_data = bus.sximm8;
         VSEL_PC:     write_data = {{(DATA_W-8){1'b0}}, bus.PC};
         VSEL_C:      write_data = c_reg;
         default:     write_data = '0;
      endcase
   end

   cpu_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .write    (bus.write),
      .writenum (bus.writenum),
      .readnum  (bus.readnum),
      .data_in  (write_data),
      .data_out (read_data)
   );

   always_comb begin
      shift_out = b_reg;
      case (bus.shift)
         SH_PASS: shift_out = b_reg;
         SH_LSL1: shift_out = {b_reg[MSB-1:0], 1'b0};
         SH_LSR1: shift_out = {1'b0, b_reg[MSB:1]};
         SH_ASR1: shift_out = {b_reg[MSB], b_reg[MSB:1]};
         default: shift_out = b_reg;
      endcase
   end

   assign ain = bus.asel ? '0 : a_reg;
   assign bin = bus.bsel ? bus.sximm5 : shift_out;

   // Overflow is judged on sign bits only; AND/MVN never overflow.
   always_comb begin
      alu_out = '0;
      ovf     = 1'b0;
      case (bus.ALUop)
         ALU_ADD: begin
            alu_out = ain + bin;
            ovf     = (ain[MSB] == bin[MSB]) && (alu_out[MSB] != ain[MSB]);
         end
         ALU_CMP: begin
            alu_out = ain - bin;
            ovf     = (ain[MSB] != bin[MSB]) && (alu_out[MSB] != ain[MSB]);
         end
         ALU_AND: alu_out = ain & bin;
         ALU_MVN: alu_out = ~bin;
         default: alu_out = '0;
      endcase
   end

   always_comb begin
      flags         = '0;
      flags[STAT_Z] = (alu_out == '0);
      flags[STAT_N] = alu_out[MSB];
      flags[STAT_V] = ovf;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg      <= '0;
         b_reg      <= '0;
         c_reg      <= '0;
         status_reg <= '0;
      end else begin
         if (bus.loada) a_reg      <= read_data;
         if (bus.loadb) b_reg      <= read_data;
         if (bus.loadc) c_reg      <= alu_out;
         if (bus.loads) status_reg <= flags;
      end
   end

   assign bus.datapath_out = c_reg;
   assign bus.status_out   = status_reg;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed instruction sequences plus
// randomized control streams against an arithmetic reference model.
module tb_cpu_datapath;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   cpu_datapath_if #(.DATA_W(16)) dif ();

   cpu_datapath #(.DATA_W(16), .NREG(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [15:0] m_regs [8];
   logic [15:0] m_a, m_b, m_c;
   logic [2:0]  m_status;

   function automatic logic [15:0] model_shift(input logic [15:0] b, input logic [1:0] op);
      int sb;
      case (op)
         2'd0: return b;
         2'd1: return 16'((int'(b) * 2) % 65536);
         2'd2: return 16'(int'(b) / 2);
         default: begin
            sb = int'($signed(b));
            return 16'(((sb < 0) && (sb % 2 != 0)) ? (sb / 2 - 1) : (sb / 2));
         end
      endcase
   endfunction

   function automatic void model_alu(input logic [15:0] x, input logic [15:0] y,
                                     input logic [1:0] op,
                                     output logic [15:0] res, output logic v);
      int sx, sy, r;
      sx = int'($signed(x));
      sy = int'($signed(y));
      v  = 1'b0;
      case (op)
         2'd0: begin r = sx + sy; res = 16'(r); v = (r > 32767) || (r < -32768); end
         2'd1: begin r = sx - sy; res = 16'(r); v = (r > 32767) || (r < -32768); end
         2'd2: res = x & y;
         default: res = ~y;
      endcase
   endfunction

   task automatic clear_ctl();
      reset        = 1'b0;
      dif.readnum  = 3'd0;
      dif.writenum = 3'd0;
      dif.write    = 1'b0;
      dif.vsel     = 2'd0;
      dif.loada    = 1'b0;
      dif.loadb    = 1'b0;
      dif.loadc    = 1'b0;
      dif.loads    = 1'b0;
      dif.asel     = 1'b0;
      dif.bsel     = 1'b0;
      dif.shift    = 2'd0;
      dif.ALUop    = 2'd0;
      dif.sximm8   = 16'd0;
      dif.sximm5   = 16'd0;
      dif.mdata    = 16'd0;
      dif.PC       = 8'd0;
   endtask

   // Advance one clock, updating the reference model from the driven inputs.
   task automatic do_cycle();
      logic [15:0] rdata, ain, bin, res, wdata;
      logic        v;
      logic [2:0]  fl;
      rdata = m_regs[dif.readnum];
      ain   = dif.asel ? 16'd0 : m_a;
      bin   = dif.bsel ? dif.sximm5 : model_shift(m_b, dif.shift);
      model_alu(ain, bin, dif.ALUop, res, v);
      fl    = {v, res[15], res == 16'd0};
      case (dif.vsel)
         2'd0: wdata = dif.mdata;
         2'd1: wdata = dif.sximm8;
         2'd2: wdata = {8'd0, dif.PC};
         default: wdata = m_c;
      endcase
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
         m_a = 16'd0; m_b = 16'd0; m_c = 16'd0; m_status = 3'd0;
      end else begin
         if (dif.write) m_regs[dif.writenum] = wdata;
         if (dif.loada) m_a = rdata;
         if (dif.loadb) m_b = rdata;
         if (dif.loadc) m_c = res;
         if (dif.loads) m_status = fl;
      end
      @(negedge clk);
      cyc++;
      $display("cyc %0d rst=%0b rd=%0d wr=%0b/%0d ld=%0b%0b%0b%0b alu=%0d out=%h st=%b",
               cyc, reset, dif.readnum, dif.write, dif.writenum, dif.loada, dif.loadb,
               dif.loadc, dif.loads, dif.ALUop, dif.datapath_out, dif.status_out);
   endtask

   task automatic set_reg(input logic [2:0] idx, input logic [15:0] val);
      clear_ctl();
      dif.sximm8 = val; dif.vsel = 2'b01; dif.writenum = idx; dif.write = 1'b1;
      do_cycle();
      clear_ctl();
   endtask

   // Observe a register through B -> pass shift -> 0+B -> C.
   task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
      clear_ctl();
      dif.readnum = idx; dif.loadb = 1'b1;
      do_cycle();
      clear_ctl();
      dif.asel = 1'b1; dif.loadc = 1'b1;
      do_cycle();
      clear_ctl();
      val = dif.datapath_out;
   endtask

   task automatic test_reset();
      logic [15:0] val;
      clear_ctl();
      reset = 1'b1; dif.loadc = 1'b1; dif.write = 1'b1; dif.vsel = 2'b01;
      dif.sximm8 = 16'h1234; dif.loada = 1'b1; dif.loads = 1'b1;
      do_cycle();
      clear_ctl();
      n_checks++;
      if (dif.datapath_out !== 16'h0000) begin
         n_fail++; $display("FAIL reset_out got=%h exp=0000", dif.datapath_out);
      end
      n_checks++;
      if (dif.status_out !== 3'b000) begin
         n_fail++; $display("FAIL reset_status got=%b exp=000", dif.status_out);
      end
      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), val);
         n_checks++;
         if (val !== 16'h0000) begin
            n_fail++; $display("FAIL reset_r%0d got=%h exp=0000", i, val);
         end
      end
   endtask

   task automatic test_mov();
      logic [15:0] val;
      set_reg(3'd0, 16'd7);
      dif.readnum = 3'd0; dif.loadb = 1'b1;
      do_cycle();
      clear_ctl();
      dif.shift = 2'b00; dif.asel = 1'b1; dif.ALUop = 2'b00; dif.loadc = 1'b1;
      do_cycle();
      clear_ctl();
      n_checks++;
      if (dif.datapath_out !== 16'h0007) begin
         n_fail++; $display("FAIL mov_out got=%h exp=0007", dif.datapath_out);
      end
      read_reg(3'd0, val);
      n_checks++;
      if (val !== 16'h0007) begin
         n_fail++; $display("FAIL mov_r0 got=%h exp=0007", val);
      end
   endtask

   task automatic test_add_lsl();
      logic [15:0] val;
      set_reg(3'd1, 16'd2);
      set_reg(3'd0, 16'd7);
      dif.readnum = 3'd1; dif.loada = 1'b1;
      do_cycle();
      clear_ctl();
      dif.readnum = 3'd0; dif.loadb = 1'b1;
      do_cycle();
      clear_ctl();
      dif.shift = 2'b01; dif.ALUop = 2'b00; dif.loadc = 1'b1;
      do_cycle();
      clear_ctl();
      n_checks++;
      if (dif.datapath_out !== 16'h0010) begin
         n_fail++; $display("FAIL add_out got=%h exp=0010", dif.datapath_out);
      end
      dif.vsel = 2'b11; dif.writenum = 3'd2; dif.write = 1'b1;
      do_cycle();
      clear_ctl();
      read_reg(3'd2, val);
      n_checks++;
      if (val !== 16'h0010) begin
         n_fail++; $display("FAIL add_r2 got=%h exp=0010", val);
      end
   endtask

   task automatic test_cmp_flags();
      set_reg(3'd4, 16'd5);
      dif.readnum = 3'd4; dif.loada = 1'b1; dif.loadb = 1'b1;
      do_cycle();
      clear_ctl();
      dif.ALUop = 2'b01; dif.loads = 1'b1;
      do_cycle();
      clear_ctl();
      n_checks++;
      if (dif.status_out !== 3'b001) begin
         n_fail++; $display("FAIL cmp_eq_status got=%b exp=001", dif.status_out);
      end
      set_reg(3'd5, 16'h7FFF);
      set_reg(3'd6, 16'hFFFF);
      dif.readnum = 3'd5; dif.loada = 1'b1;
      do_cycle();
      clear_ctl();
      dif.readnum = 3'd6; dif.loadb = 1'b1;
      do_cycle();
      clear_ctl();
      dif.ALUop = 2'b01; dif.loads = 1'b1; dif.loadc = 1'b1;
      do_cycle();
      clear_ctl();
      n_checks++;
      if (dif.status_out !== 3'b110) begin
         n_fail++; $display("FAIL cmp_ovf_status got=%b exp=110", dif.status_out);
      end
      n_checks++;
      if (dif.datapath_out !== 16'h8000) begin
         n_fail++; $display("FAIL cmp_ovf_result got=%h exp=8000", dif.datapath_out);
      end
      dif.readnum = 3'd4; dif.loada = 1'b1;
      do_cycle();
      clear_ctl();
      dif.ALUop = 2'b01; dif.loads = 1'b0;
      do_cycle();
      clear_ctl();
      n_checks++;
      if (dif.status_out !== 3'b110) begin
         n_fail++; $display("FAIL cmp_hold_status got=%b exp=110", dif.status_out);
      end
   endtask

   task automatic test_mvn_asr();
      set_reg(3'd7, 16'h8004);
      dif.readnum = 3'd7; dif.loadb = 1'b1;
      do_cycle();
      clear_ctl();
      dif.shift = 2'b11; dif.ALUop = 2'b11; dif.loadc = 1'b1;
      do_cycle();
      clear_ctl();
      n_checks++;
      if (dif.datapath_out !== 16'h3FFD) begin
         n_fail++; $display("FAIL mvn_asr_out got=%h exp=3ffd", dif.datapath_out);
      end
   endtask

   task automatic test_same_cycle_rw();
      logic [15:0] val;
      set_reg(3'd3, 16'h0001);
      dif.sximm8 = 16'h00AA; dif.vsel = 2'b01; dif.writenum = 3'd3; dif.write = 1'b1;
      dif.readnum = 3'd3; dif.loada = 1'b1;
      do_cycle();
      clear_ctl();
      dif.bsel = 1'b1; dif.sximm5 = 16'd0; dif.ALUop = 2'b00; dif.loadc = 1'b1;
      do_cycle();
      clear_ctl();
      n_checks++;
      if (dif.datapath_out !== 16'h0001) begin
         n_fail++; $display("FAIL rw_a_old got=%h exp=0001", dif.datapath_out);
      end
      read_reg(3'd3, val);
      n_checks++;
      if (val !== 16'h00AA) begin
         n_fail++; $display("FAIL rw_r3_new got=%h exp=00aa", val);
      end
   endtask

   task automatic test_random();
      logic [15:0] val;
      for (int n = 0; n < 300; n++) begin
         reset        = ($urandom_range(0, 39) == 0);
         dif.readnum  = 3'($urandom);
         dif.writenum = 3'($urandom);
         dif.write    = 1'($urandom);
         dif.vsel     = 2'($urandom);
         dif.loada    = 1'($urandom);
         dif.loadb    = 1'($urandom);
         dif.loadc    = 1'($urandom);
         dif.loads    = 1'($urandom);
         dif.asel     = 1'($urandom);
         dif.bsel     = 1'($urandom);
         dif.shift    = 2'($urandom);
         dif.ALUop    = 2'($urandom);
         dif.sximm8   = 16'($urandom);
         dif.sximm5   = 16'($urandom);
         dif.mdata    = 16'($urandom);
         dif.PC       = 8'($urandom);
         do_cycle();
         n_checks++;
         if (dif.datapath_out !== m_c) begin
            n_fail++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", cyc, dif.datapath_out, m_c);
         end
         n_checks++;
         if (dif.status_out !== m_status) begin
            n_fail++; $display("FAIL rand_status cyc=%0d got=%b exp=%b", cyc, dif.status_out, m_status);
         end
      end
      clear_ctl();
      for (int i = 0; i < 8; i++) begin
         logic [15:0] exp_val;
         exp_val = m_regs[i];
         read_reg(3'(i), val);
         n_checks++;
         if (val !== exp_val) begin
            n_fail++; $display("FAIL rand_r%0d got=%h exp=%h", i, val, exp_val);
         end
      end
   endtask

   initial begin
      clear_ctl();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
      m_a = 16'd0; m_b = 16'd0; m_c = 16'd0; m_status = 3'd0;
      @(negedge clk);
      test_reset();
      test_mov();
      test_add_lsl();
      test_cmp_flags();
      test_mvn_asr();
      test_same_cycle_rw();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Datapath directly downstream of the instruction-sequencing controller. It holds the 8-entry register file, the A/B/C pipeline registers, the shifter, the ALU and the status register.
- Every control input (write, vsel, loada, loadb, loadc, loads, asel, bsel) is driven by the controller one state at a time.
- The instruction decoder supplies readnum, writenum, shift, ALUop and the sign-extended immediates.
- Results leave on datapath_out, which is written back through vsel=11. Flags leave on status_out.

Parameters:
- DATA_W, 16, datapath word width. Immediates and mdata match it.
- NREG, 8, number of general registers. Register index width is fixed at 3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- readnum  in  3  register-file read index (combinational read)
- writenum  in  3  register-file write index
- write  in  1  register-file write enable
- vsel  in  2  write-data select: 00 mdata, 01 sximm8, 10 {8'b0,PC}, 11 C
- loada  in  1  load A register from read port
- loadb  in  1  load B register from read port
- loadc  in  1  load C register from ALU result
- loads  in  1  load status register from ALU flags
- asel  in  1  1: ALU A operand = 0; 0: A register
- bsel  in  1  1: ALU B operand = sximm5; 0: shifter output
- shift  in  2  shifter op applied to B register
- ALUop  in  2  ALU op
- sximm8  in  16  sign-extended 8-bit immediate
- sximm5  in  16  sign-extended 5-bit immediate
- mdata  in  16  memory read data (tied 0 in this lab)
- PC  in  8  program counter (tied 0 in this lab)
- datapath_out  out  16  C register contents
- status_out  out  3  {V,N,Z} status register contents

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - R0-R7, A, B, C and status all clear to 0, so datapath_out=0 and status_out=000.
  - Reset has priority over every load and write in the same cycle.
  - Reset asserted mid-instruction discards the in-flight operation.
- Register file:
  - Read is combinational: data_out = R[readnum].
  - Write occurs at posedge when write=1: R[writenum] <= vsel-selected data.
  - Read and write of the same index in the same cycle returns the old value, and the new value is visible next cycle.
- A, B, C and status are independent enable flops, each loaded at posedge when its enable is 1; otherwise each holds.
  - loada and loadb may both be 1 in the same cycle; both capture the same read data.
- Shifter (pure combinational, on B):
  - 00 pass
  - 01 LSL1 (lsb=0)
  - 10 LSR1 (msb=0)
  - 11 ASR1 (msb replicated)
- ALU (combinational):
  - 00 Ain+Bin
  - 01 Ain-Bin
  - 10 Ain&Bin
  - 11 ~Bin
  - All results are modulo 2^16; no carry out.
- Flags, computed from the combinational ALU result and captured only on loads:
  - Z = (result==0)
  - N = result[15]
  - V = signed overflow: add = same-sign operands giving a different-sign result; sub = different-sign operands with result sign != Ain sign; 0 for AND/MVN.
- Latency from an instruction's first operand read to datapath_out is fixed by the controller sequence.
  - Register→A/B: 1 clk. A/B→C: 1 clk. C→register write via vsel=11: 1 clk.
  - The datapath adds no internal pipelining or stalls.
- Undefined vsel, shift or ALUop codes do not exist: all 2-bit codes are defined above.
- X on an enable that is 0 must not corrupt state.

Decomposition:
- Shared package cpu_pkg holds:
  - vsel encodings (VSEL_MDATA/SXIMM8/PC/C)
  - shift encodings
  - ALU op encodings (ADD/CMP-sub/AND/MVN, identical to the controller's op field)
  - status bit positions
- One sub-module: cpu_regfile (NREG×DATA_W, 1 combinational read port, 1 synchronous write port, synchronous reset).
- Shifter and ALU stay inline as combinational blocks.

Test Plan:
- Reset: assert reset 1 clk with loadc=1, write=1 → datapath_out=0x0000, status_out=000, and R0-R7 all read 0.
- MOV R0,#7:
  - Stimulus: sximm8=7, vsel=01, writenum=0, write=1 for 1 clk.
  - Then readnum=0, loadb; shift=00, asel=1, ALUop=00, loadc.
  - Expect datapath_out=0x0007 and R0=7.
- ADD R2,R1,R0,LSL#1:
  - Stimulus: R1=2, R0=7; load A←R1 and B←R0; shift=01, ALUop=00, loadc; then vsel=11, writenum=2, write.
  - Expect datapath_out=0x0010 and R2=0x0010.
- CMP flags:
  - A=5, B=5, ALUop=01, loads → status_out=001 (Z=1).
  - A=0x7FFF, B=0xFFFF, ALUop=01, loads → result 0x8000, status_out=110 (V=1, N=1, Z=0).
  - loads=0 on a following compare → status unchanged.
- MVN with ASR: B=0x8004, shift=11, ALUop=11, loadc → datapath_out=0x3FFD.
- Same-cycle read/write of R3:
  - Stimulus: R3=0x0001; write R3←0x00AA while readnum=3, loada=1.
  - Expect A captures 0x0001; the next-cycle read returns 0x00AA.
